ctrl_seq: RTL

//  Controller-sequencer for the 8-bit accumulator machine. Six-state one-hot ring counter (T1..T6)

---
 rtl/ctrl_seq_if.sv | 40 ++++
 rtl/ctrl_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/ctrl_seq_if.sv
// Control-word bundle between the sequencer and the accumulator datapath.
// The master side is the sequencer: it receives run/step/opcode and drives
// every control line plus the status outputs. The slave side is whatever
// consumes the control word: the datapath, a front panel or a bench.
//
// Protocol: there is no valid/ready pair. A control word is meaningful only
// in the cycle it is driven. When the sequencer does not advance, every
// control line is 0, so a non-zero line always means "act at this edge".
interface ctrl_seq_if;
  logic       run;
  logic       step;
  logic [3:0] opcode;
  logic       cp;
  logic       ep;
  logic       lm;
  logic       ce;
  logic       li;
  logic       ei;
  logic       la;
  logic       ea;
  logic       su;
  logic       eu;
  logic       lb;
  logic       lo;
  logic       hlt;
  logic [5:0] tstate;
  logic       instr_done;

  modport master (
    input  run, step, opcode,
    output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo,
    output hlt, tstate, instr_done
  );

  modport slave (
    output run, step, opcode,
    input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo,
    input  hlt, tstate, instr_done
  );
endinterface

// File: rtl/ctrl_seq.sv
// Controller-sequencer for the 8-bit accumulator machine.
// A six-state one-hot ring (T1..T6) walks the fetch/execute cycle. The
// control word is decoded combinationally from the ring and the IR opcode
// nibble, and it is gated by the advance condition. This means a stalled
// cycle (single-step wait, halt) never repeats a pc increment or a load.
module ctrl_seq (
  input  logic       clk,
  input  logic       clr,
  ctrl_seq_if.master bus
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Control word bit positions: {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo}
  localparam logic [11:0] CW_CP = 12'b1000_0000_0000;
  localparam logic [11:0] CW_EP = 12'b0100_0000_0000;
  localparam logic [11:0] CW_LM = 12'b0010_0000_0000;
  localparam logic [11:0] CW_CE = 12'b0001_0000_0000;
  localparam logic [11:0] CW_LI = 12'b0000_1000_0000;
  localparam logic [11:0] CW_EI = 12'b0000_0100_0000;
  localparam logic [11:0] CW_LA = 12'b0000_0010_0000;
  localparam logic [11:0] CW_EA = 12'b0000_0001_0000;
  localparam logic [11:0] CW_SU = 12'b0000_0000_1000;
  localparam logic [11:0] CW_EU = 12'b0000_0000_0100;
  localparam logic [11:0] CW_LB = 12'b0000_0000_0010;
  localparam logic [11:0] CW_LO = 12'b0000_0000_0001;

  logic [5:0]  tstate;
  logic        halted;
  logic        step_q;
  logic        adv;
  logic [11:0] cw;

  // Advance in free-run, or once per rising edge of step. Halt blocks both.
  assign adv = ~halted & (bus.run | (bus.step & ~step_q));

  // Ring counter, halt latch and step edge history.
  always_ff @(posedge clk) begin
    if (clr) begin
      tstate <= T1;
      halted <= 1'b0;
      step_q <= 1'b0;
    end else begin
      step_q <= bus.step;
      if (adv) begin
        if (tstate == T4 && bus.opcode == OP_HLT) begin
          halted <= 1'b1;
        end else begin
          tstate <= {tstate[4:0], tstate[5]};
        end
      end
    end
  end

  // Decode the ring state and opcode into the control word for this cycle.
  always_comb begin
    cw = '0;
    if (!clr && adv) begin
      case (tstate)
        T1: cw = CW_EP | CW_LM;
        T2: cw = CW_CP;
        T3: cw = CW_CE | CW_LI;
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: cw = CW_EI | CW_LM;
            OP_OUT:                 cw = CW_EA | CW_LO;
            default:                cw = '0;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA:         cw = CW_CE | CW_LA;
            OP_ADD, OP_SUB: cw = CW_CE | CW_LB;
            default:        cw = '0;
          endcase
        end
        T6: begin
          case (bus.opcode)
            OP_ADD:  cw = CW_EU | CW_LA;
            OP_SUB:  cw = CW_EU | CW_LA | CW_SU;
            default: cw = '0;
          endcase
        end
        default: cw = '0;
      endcase
    end
  end

  assign bus.cp = cw[11];
  assign bus.ep = cw[10];
  assign bus.lm = cw[9];
  assign bus.ce = cw[8];
  assign bus.li = cw[7];
  assign bus.ei = cw[6];
  assign bus.la = cw[5];
  assign bus.ea = cw[4];
  assign bus.su = cw[3];
  assign bus.eu = cw[2];
  assign bus.lb = cw[1];
  assign bus.lo = cw[0];

  assign bus.hlt        = halted;
  assign bus.tstate     = tstate;
  assign bus.instr_done = ~clr & adv & tstate[5];

endmodule
